multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OP_W, default 7, opcode width.
REQ-002 Parameter ALUOP_W, default 2, ALU operation code width; must be at least 2.
REQ-003 Parameter TIMEOUT, default 16, maximum memory-wait cycles before fault.
REQ-004 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset; synchronous, active-high.
REQ-007 start_i  in  1  level run enable.
REQ-008 Op_i  in  OP_W  opcode field of instruction register; sampled in DECODE only.
REQ-009 mem_ready_i  in  1  memory completion handshake.
REQ-010 ALUOp_o  out  ALUOP_W; ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, Branch_o, PCWrite_o, IRWrite_o  out  1 each: datapath controls.
REQ-011 state_o  out  3  current FSM state encoding.
REQ-012 illegal_o, timeout_o  out  1 each: sticky fault flags.
REQ-013 retired_o  out  CNT_W  retired count; present only under CTRL_PERF_CNT_EN.

Function
REQ-014 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; value 7 is unreachable and SHALL map to HALT.
REQ-015 IDLE -> FETCH when start_i=1; otherwise stay in IDLE.
REQ-016 FETCH: MemRead_o=1 held until mem_ready_i=1; in that same cycle IRWrite_o=1 and PCWrite_o=1 (Mealy), then -> DECODE.
REQ-017 DECODE: one cycle; latch Op_i into internal op register; R=0110011, I=0010011, LOAD=0000011, STORE=0100011 and BRANCH=1100011 -> EXEC; any other value -> HALT with illegal_o set.
REQ-018 EXEC, one cycle, ALUOp_o/ALUSrc_o by class: R 10/0, I 11/1, LOAD/STORE 00/1, BRANCH 01/0; upper ALUOp bits zero when ALUOP_W>2.
REQ-019 EXEC exit: R/I -> WB; LOAD/STORE -> MEM; BRANCH asserts Branch_o=1, then -> FETCH if start_i=1, else IDLE.
REQ-020 MEM: LOAD holds MemRead_o=1 and STORE holds MemWrite_o=1 until mem_ready_i=1; on ready, LOAD -> WB and STORE -> FETCH/IDLE per start_i.
REQ-021 WB: RegWrite_o=1 for one cycle, MemtoReg_o=1 for LOAD only, then -> FETCH if start_i=1, else IDLE.
REQ-022 start_i deassertion mid-instruction never aborts; IDLE is entered only at a retire point.
REQ-023 Wait counter clears on entry to FETCH/MEM, increments per non-ready cycle; reaching TIMEOUT -> HALT with timeout_o set; mem_ready_i on the TIMEOUT-th cycle wins.
REQ-024 HALT: all controls 0, exit only by rst_i; fault flags remain set until reset.
REQ-025 Controls not explicitly asserted in a state SHALL be 0; all controls 0 in IDLE.

Reset
REQ-026 rst_i=1 at any edge, including mid-MEM: state IDLE, wait counter 0, op register 0, illegal_o=0, timeout_o=0, retired_o=0; rst_i dominates start_i.

Configuration
REQ-027 Macro CTRL_PERF_CNT_EN: when defined, retired_o increments by 1 at each retire point (WB exit, STORE completion, BRANCH EXEC) and wraps modulo 2^CNT_W.
REQ-028 Without CTRL_PERF_CNT_EN: no retired_o port and no counter logic; all other behaviour identical.

Structure
REQ-029 Package ctrl_pkg holds the state enum, opcode constants, instruction-class enum and ALUOp encodings.
REQ-030 Sub-module ctrl_decode: combinational opcode -> class/illegal classifier, instantiated once.

Verification
REQ-031 R-type 0110011, mem_ready_i=1 immediately -> states 1,2,3,5,1; ALUOp_o=10 in EXEC; RegWrite_o=1 for exactly 1 cycle.
REQ-032 LOAD with mem_ready_i delayed 3 cycles in MEM -> MemRead_o high 4 cycles; WB with MemtoReg_o=1.
REQ-033 Opcode 1111111 -> HALT one cycle after DECODE; illegal_o=1 held until rst_i.
REQ-034 mem_ready_i=0 in FETCH for TIMEOUT=4 cycles -> HALT, timeout_o=1; repeat with ready on 4th cycle -> DECODE, no fault.
REQ-035 start_i dropped during MEM of STORE -> MemWrite_o completes, then IDLE; rst_i pulsed mid-MEM -> IDLE and all outputs 0 next cycle.
REQ-036 With CTRL_PERF_CNT_EN and CNT_W=2: 5 retired instructions -> retired_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes,
// instruction classes, ALUOp codes and the per-state control bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } cls_e;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_t;

    // Moore controls for a state, given the class of the instruction in flight.
    function automatic ctrl_t ctrl_for(state_e s, cls_e c);
        ctrl_t r;
        r = '0;
        case (s)
            S_FETCH: r.mem_read = 1'b1;
            S_EXEC: begin
                case (c)
                    CLS_R:      r.alu_op = ALUOP_R;
                    CLS_I:      begin r.alu_op = ALUOP_I;   r.alu_src = 1'b1; end
                    CLS_LOAD,
                    CLS_STORE:  begin r.alu_op = ALUOP_MEM; r.alu_src = 1'b1; end
                    CLS_BRANCH: begin r.alu_op = ALUOP_BRANCH; r.branch = 1'b1; end
                    default:    r = '0;
                endcase
            end
            S_MEM: begin
                r.mem_read  = (c == CLS_LOAD);
                r.mem_write = (c == CLS_STORE);
            end
            S_WB: begin
                r.reg_write  = 1'b1;
                r.mem_to_reg = (c == CLS_LOAD);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/memory handshake and datapath control bus of the multicycle controller.
interface multicycle_control_if #(
    parameter int OP_W    = 7,
    parameter int ALUOP_W = 2
);
    logic               start_i;
    logic [OP_W-1:0]    Op_i;
    logic               mem_ready_i;
    logic [ALUOP_W-1:0] ALUOp_o;
    logic               ALUSrc_o;
    logic               RegWrite_o;
    logic               MemRead_o;
    logic               MemWrite_o;
    logic               MemtoReg_o;
    logic               Branch_o;
    logic               PCWrite_o;
    logic               IRWrite_o;

    modport master (
        output start_i, Op_i, mem_ready_i,
        input  ALUOp_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o,
               MemtoReg_o, Branch_o, PCWrite_o, IRWrite_o
    );

    modport slave (
        input  start_i, Op_i, mem_ready_i,
        output ALUOp_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o,
               MemtoReg_o, Branch_o, PCWrite_o, IRWrite_o
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: maps an opcode to its instruction class
// and flags anything outside the supported set as illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 7
) (
    input  logic [OP_W-1:0] op_i,
    output cls_e            cls_o,
    output logic            illegal_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives cls_o and no latch is inferred.
        cls_o = CLS_NONE;
        case (op_i)
            OP_W'(OPC_R):      cls_o = CLS_R;
            OP_W'(OPC_I):      cls_o = CLS_I;
            OP_W'(OPC_LOAD):   cls_o = CLS_LOAD;
            OP_W'(OPC_STORE):  cls_o = CLS_STORE;
            OP_W'(OPC_BRANCH): cls_o = CLS_BRANCH;
            default:           cls_o = CLS_NONE;
        endcase
        illegal_o = (cls_o == CLS_NONE);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with memory-wait timeout and sticky fault flags.
// Define CTRL_PERF_CNT_EN to add the retired-instruction counter and retired_o port.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 7,
    parameter int ALUOP_W = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    multicycle_control_if.slave   bus,
    output logic [2:0]            state_o,
    output logic                  illegal_o,
    output logic                  timeout_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      retired_o
`endif
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    if (ALUOP_W < 2 || CNT_W < 1) begin : g_param_check
        $error("multicycle_control: ALUOP_W must be >= 2 and CNT_W >= 1");
    end

    state_e            state_q, state_d;
    state_e            retire_next;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    ctrl_t             ctrl_q, ctrl_d;
    cls_e              cls;
    logic              op_bad;

    // The opcode register only loads in DECODE; classifying op_d covers both the
    // DECODE decision and the class of the instruction already held.
    assign op_d        = (state_q == S_DECODE) ? bus.Op_i : op_q;
    assign retire_next = bus.start_i ? S_FETCH : S_IDLE;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .op_i      (op_d),
        .cls_o     (cls),
        .illegal_o (op_bad)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE:   if (bus.start_i) state_d = S_FETCH;
            S_FETCH,
            S_MEM: begin
                // Ready on the final allowed cycle completes rather than faulting.
                if (bus.mem_ready_i) begin
                    if (state_q == S_FETCH)   state_d = S_DECODE;
                    else if (cls == CLS_LOAD) state_d = S_WB;
                    else                      state_d = retire_next;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                state_d   = op_bad ? S_HALT : S_EXEC;
                illegal_d = illegal_q | op_bad;
            end
            S_EXEC: begin
                if (cls == CLS_BRANCH)                  state_d = retire_next;
                else if (cls == CLS_R || cls == CLS_I)  state_d = S_WB;
                else                                    state_d = S_MEM;
            end
            S_WB:     state_d = retire_next;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
        ctrl_d = ctrl_for(state_d, cls);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            ctrl_q    <= ctrl_d;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] retired_q, retired_d;

    assign retire = (state_q == S_WB)
                  || (state_q == S_EXEC && cls == CLS_BRANCH)
                  || (state_q == S_MEM && cls == CLS_STORE && bus.mem_ready_i);
    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign retired_o = retired_q;
`endif

    assign bus.ALUOp_o    = ALUOP_W'(ctrl_q.alu_op);
    assign bus.ALUSrc_o   = ctrl_q.alu_src;
    assign bus.RegWrite_o = ctrl_q.reg_write;
    assign bus.MemRead_o  = ctrl_q.mem_read;
    assign bus.MemWrite_o = ctrl_q.mem_write;
    assign bus.MemtoReg_o = ctrl_q.mem_to_reg;
    assign bus.Branch_o   = ctrl_q.branch;
    // Instruction fetch completes in the ready cycle itself, so these two are Mealy.
    assign bus.PCWrite_o  = (state_q == S_FETCH) && bus.mem_ready_i;
    assign bus.IRWrite_o  = (state_q == S_FETCH) && bus.mem_ready_i;

    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expectations are queued as
// stimulus is driven and compared against the sampled outputs at the end of each scenario.
module tb_multicycle_control;

    localparam int OP_W    = 7;
    localparam int ALUOP_W = 2;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_X  = 7'b1111111;

    // {ALUOp[1:0], ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch, PCWrite, IRWrite}
    localparam logic [9:0] C_0   = 10'b00_0000_0000;
    localparam logic [9:0] C_F   = 10'b00_0010_0000;
    localparam logic [9:0] C_FR  = 10'b00_0010_0011;
    localparam logic [9:0] C_ER  = 10'b10_0000_0000;
    localparam logic [9:0] C_EI  = 10'b11_1000_0000;
    localparam logic [9:0] C_ELS = 10'b00_1000_0000;
    localparam logic [9:0] C_EB  = 10'b01_0000_0100;
    localparam logic [9:0] C_MR  = 10'b00_0010_0000;
    localparam logic [9:0] C_MW  = 10'b00_0001_0000;
    localparam logic [9:0] C_WB  = 10'b00_0100_0000;
    localparam logic [9:0] C_WBL = 10'b00_0100_1000;

    typedef struct packed {
        logic [2:0] st;
        logic [9:0] ctl;
        logic       ill;
        logic       to;
    } obs_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic [2:0] state_o;
    logic       illegal_o;
    logic       timeout_o;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retired_o;
    logic [CNT_W-1:0] last_retired;
`endif

    obs_t exp_q[$];
    obs_t got_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_control_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) bus_if ();

    multicycle_control #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus       (bus_if),
        .state_o   (state_o),
        .illegal_o (illegal_o),
`ifdef CTRL_PERF_CNT_EN
        .retired_o (retired_o),
`endif
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // One cycle: drive inputs just after the edge, queue the expected outputs for the
    // state the DUT entered on that edge, and sample the outputs on the falling edge.
    task automatic drive(input logic rst, input logic st, input logic [6:0] op,
                         input logic rdy, input logic [2:0] est, input logic [9:0] ectl,
                         input logic eill = 1'b0, input logic eto = 1'b0);
        obs_t e, g;
        @(posedge clk_i);
        #1;
        rst_i              = rst;
        bus_if.start_i     = st;
        bus_if.Op_i        = op;
        bus_if.mem_ready_i = rdy;
        e = '{st: est, ctl: ectl, ill: eill, to: eto};
        exp_q.push_back(e);
        @(negedge clk_i);
        g.st  = state_o;
        g.ctl = {bus_if.ALUOp_o, bus_if.ALUSrc_o, bus_if.RegWrite_o, bus_if.MemRead_o,
                 bus_if.MemWrite_o, bus_if.MemtoReg_o, bus_if.Branch_o,
                 bus_if.PCWrite_o, bus_if.IRWrite_o};
        g.ill = illegal_o;
        g.to  = timeout_o;
        got_q.push_back(g);
`ifdef CTRL_PERF_CNT_EN
        last_retired = retired_o;
`endif
    endtask

    task automatic apply_reset();
        @(posedge clk_i);
        #1;
        rst_i              = 1'b1;
        bus_if.start_i     = 1'b0;
        bus_if.Op_i        = '0;
        bus_if.mem_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, g;
        int   row = 0;
        drive(1, 1, OP_X, 1, 3'd0, C_0);
        drive(1, 1, OP_X, 1, 3'd0, C_0);
        drive(0, 0, OP_X, 1, 3'd0, C_0);
        drive(0, 0, OP_X, 0, 3'd0, C_0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset row %0d: got st=%0d ctl=%b ill=%b to=%b, expected st=%0d ctl=%b ill=%b to=%b",
                         row, g.st, g.ctl, g.ill, g.to, e.st, e.ctl, e.ill, e.to);
            end
            row++;
        end
    endtask

    task automatic test_r_type();
        obs_t e, g;
        int   row = 0;
        apply_reset();
        drive(0, 1, OP_X, 0, 3'd0, C_0);
        drive(0, 1, OP_X, 1, 3'd1, C_FR);
        drive(0, 1, OP_R, 0, 3'd2, C_0);
        drive(0, 1, OP_X, 0, 3'd3, C_ER);
        drive(0, 1, OP_X, 0, 3'd5, C_WB);
        drive(0, 0, OP_X, 0, 3'd1, C_F);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL r_type row %0d: got st=%0d ctl=%b ill=%b to=%b, expected st=%0d ctl=%b ill=%b to=%b",
                         row, g.st, g.ctl, g.ill, g.to, e.st, e.ctl, e.ill, e.to);
            end
            row++;
        end
    endtask

    task automatic test_load_wait();
        obs_t e, g;
        int   row = 0;
        apply_reset();
        drive(0, 1, OP_X,  0, 3'd0, C_0);
        drive(0, 1, OP_X,  1, 3'd1, C_FR);
        drive(0, 1, OP_LD, 0, 3'd2, C_0);
        drive(0, 1, OP_X,  0, 3'd3, C_ELS);
        drive(0, 1, OP_X,  0, 3'd4, C_MR);
        drive(0, 1, OP_X,  0, 3'd4, C_MR);
        drive(0, 1, OP_X,  0, 3'd4, C_MR);
        drive(0, 1, OP_X,  1, 3'd4, C_MR);
        drive(0, 0, OP_X,  0, 3'd5, C_WBL);
        drive(0, 0, OP_X,  0, 3'd0, C_0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL load_wait row %0d: got st=%0d ctl=%b ill=%b to=%b, expected st=%0d ctl=%b ill=%b to=%b",
                         row, g.st, g.ctl, g.ill, g.to, e.st, e.ctl, e.ill, e.to);
            end
            row++;
        end
    endtask

    task automatic test_illegal();
        obs_t e, g;
        int   row = 0;
        apply_reset();
        drive(0, 1, OP_X, 0, 3'd0, C_0);
        drive(0, 1, OP_X, 1, 3'd1, C_FR);
        drive(0, 1, OP_X, 1, 3'd2, C_0);
        drive(0, 1, OP_R, 1, 3'd6, C_0, 1'b1);
        drive(0, 1, OP_R, 1, 3'd6, C_0, 1'b1);
        drive(0, 1, OP_R, 1, 3'd6, C_0, 1'b1);
        apply_reset();
        drive(0, 0, OP_X, 0, 3'd0, C_0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL illegal row %0d: got st=%0d ctl=%b ill=%b to=%b, expected st=%0d ctl=%b ill=%b to=%b",
                         row, g.st, g.ctl, g.ill, g.to, e.st, e.ctl, e.ill, e.to);
            end
            row++;
        end
    endtask

    task automatic test_timeout();
        obs_t e, g;
        int   row = 0;
        apply_reset();
        drive(0, 1, OP_X, 0, 3'd0, C_0);
        for (int i = 0; i < TIMEOUT; i++) drive(0, 1, OP_X, 0, 3'd1, C_F);
        drive(0, 1, OP_X, 1, 3'd6, C_0, 1'b0, 1'b1);
        drive(0, 1, OP_X, 1, 3'd6, C_0, 1'b0, 1'b1);
        apply_reset();
        drive(0, 1, OP_X, 0, 3'd0, C_0);
        for (int i = 0; i < TIMEOUT - 1; i++) drive(0, 1, OP_X, 0, 3'd1, C_F);
        drive(0, 1, OP_X, 1, 3'd1, C_FR);
        drive(0, 1, OP_I, 0, 3'd2, C_0);
        drive(0, 0, OP_X, 0, 3'd3, C_EI);
        drive(0, 0, OP_X, 0, 3'd5, C_WB);
        drive(0, 0, OP_X, 0, 3'd0, C_0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL timeout row %0d: got st=%0d ctl=%b ill=%b to=%b, expected st=%0d ctl=%b ill=%b to=%b",
                         row, g.st, g.ctl, g.ill, g.to, e.st, e.ctl, e.ill, e.to);
            end
            row++;
        end
    endtask

    task automatic test_store_stop();
        obs_t e, g;
        int   row = 0;
        apply_reset();
        drive(0, 1, OP_X,  0, 3'd0, C_0);
        drive(0, 1, OP_X,  1, 3'd1, C_FR);
        drive(0, 1, OP_ST, 0, 3'd2, C_0);
        drive(0, 1, OP_X,  0, 3'd3, C_ELS);
        drive(0, 0, OP_X,  0, 3'd4, C_MW);
        drive(0, 0, OP_X,  0, 3'd4, C_MW);
        drive(0, 0, OP_X,  1, 3'd4, C_MW);
        drive(0, 0, OP_X,  0, 3'd0, C_0);
        // Second instruction: reset lands while a load waits in MEM.
        drive(0, 1, OP_X,  0, 3'd0, C_0);
        drive(0, 1, OP_X,  1, 3'd1, C_FR);
        drive(0, 1, OP_LD, 0, 3'd2, C_0);
        drive(0, 1, OP_X,  0, 3'd3, C_ELS);
        drive(1, 1, OP_X,  1, 3'd4, C_MR);
        drive(0, 0, OP_X,  1, 3'd0, C_0);
        drive(0, 0, OP_X,  0, 3'd0, C_0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL store_stop row %0d: got st=%0d ctl=%b ill=%b to=%b, expected st=%0d ctl=%b ill=%b to=%b",
                         row, g.st, g.ctl, g.ill, g.to, e.st, e.ctl, e.ill, e.to);
            end
            row++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        int   row = 0;
        apply_reset();
        drive(0, 1, OP_X,  0, 3'd0, C_0);
        drive(0, 1, OP_X,  1, 3'd1, C_FR);
        drive(0, 1, OP_BR, 0, 3'd2, C_0);
        drive(0, 1, OP_X,  0, 3'd3, C_EB);
        drive(0, 1, OP_X,  1, 3'd1, C_FR);
        drive(0, 1, OP_I,  0, 3'd2, C_0);
        drive(0, 1, OP_X,  0, 3'd3, C_EI);
        drive(0, 1, OP_X,  0, 3'd5, C_WB);
        drive(0, 0, OP_X,  0, 3'd1, C_F);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL back_to_back row %0d: got st=%0d ctl=%b ill=%b to=%b, expected st=%0d ctl=%b ill=%b to=%b",
                         row, g.st, g.ctl, g.ill, g.to, e.st, e.ctl, e.ill, e.to);
            end
            row++;
        end
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic test_perf_cnt();
        logic [CNT_W-1:0] ret_q[$];
        logic [CNT_W-1:0] r;
        obs_t e, g;
        int   row = 0;
        apply_reset();
        drive(0, 1, OP_X, 0, 3'd0, C_0);
        ret_q.push_back('0);
        for (int k = 0; k <= 5; k++) begin
            drive(0, 1, OP_X, 1, 3'd1, C_FR);
            r = ret_q.pop_front(); n_checks++;
            if (last_retired !== r) begin
                n_fail++;
                $display("FAIL perf_cnt after %0d branches: got retired=%0d expected %0d", k, last_retired, r);
            end
            if (k < 5) begin
                drive(0, 1, OP_BR, 0, 3'd2, C_0);
                drive(0, 1, OP_X,  0, 3'd3, C_EB);
                ret_q.push_back(CNT_W'((k + 1) % (1 << CNT_W)));
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL perf_cnt row %0d: got st=%0d ctl=%b ill=%b to=%b, expected st=%0d ctl=%b ill=%b to=%b",
                         row, g.st, g.ctl, g.ill, g.to, e.st, e.ctl, e.ill, e.to);
            end
            row++;
        end
    endtask
`endif

    initial begin
        bus_if.start_i     = 1'b0;
        bus_if.Op_i        = '0;
        bus_if.mem_ready_i = 1'b0;
        apply_reset();
        test_reset();
        test_r_type();
        test_load_wait();
        test_illegal();
        test_timeout();
        test_store_stop();
        test_back_to_back();
`ifdef CTRL_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
